// File: rtl/multiplier_dispatch.sv
// Dispatch stage ahead of the Multiplier: buffers operand pairs in a FIFO and
// issues them one at a time. Optional watchdog under MULTIPLIER_DISPATCH_TIMEOUT_EN.
module multiplier_dispatch #(
  parameter int unsigned BITS    = 8,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [BITS-1:0]          i_multiplier,
  input  logic [BITS-1:0]          i_multiplicand,
  output logic                     o_start,
  output logic [BITS-1:0]          o_multiplier,
  output logic [BITS-1:0]          o_multiplicand,
  input  logic                     i_finished,
  output logic                     o_busy,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_timeout
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned PAIR_W = 2 * BITS;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  logic [PAIR_W-1:0] mem_q [DEPTH];

  logic [1:0]       state_q,  state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic [BITS-1:0]  opa_q,    opa_d;
  logic [BITS-1:0]  opb_q,    opb_d;
  logic             start_q,  start_d;
  logic             busy_q,   busy_d;
  logic             push;
  logic             pop;
  logic             fifo_empty;
  logic [PAIR_W-1:0] head;

`ifdef MULTIPLIER_DISPATCH_TIMEOUT_EN
  localparam int unsigned WCNT_W = $clog2(TIMEOUT + 1);
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              timeout_q, timeout_d;
`endif

  // ready comes from the registered count, so a full FIFO never accepts even while popping
  assign o_ready    = (count_q != CNT_W'(DEPTH));
  assign fifo_empty = (count_q == '0);
  assign push       = i_valid && o_ready;
  assign head       = mem_q[rd_ptr_q];

  // FIFO storage; contents are don't-care until written
  always_ff @(posedge i_clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {i_multiplier, i_multiplicand};
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
`ifdef MULTIPLIER_DISPATCH_TIMEOUT_EN
    wcnt_d    = wcnt_q;
    timeout_d = timeout_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
`ifdef MULTIPLIER_DISPATCH_TIMEOUT_EN
        wcnt_d  = '0;
`endif
      end
      ST_WAIT: begin
        if (i_finished) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_IDLE;
          end
        end
`ifdef MULTIPLIER_DISPATCH_TIMEOUT_EN
        // a finish on the limit cycle takes priority over the watchdog
        else if (wcnt_q == WCNT_W'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    start_d  = (state_d == ST_ISSUE);
    busy_d   = (state_d == ST_ISSUE) || (state_d == ST_WAIT);

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    opa_d = pop ? head[PAIR_W-1:BITS] : opa_q;
    opb_d = pop ? head[BITS-1:0]      : opb_q;
  end

  // State and output registers
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      start_q  <= start_d;
      busy_q   <= busy_d;
    end
  end

`ifdef MULTIPLIER_DISPATCH_TIMEOUT_EN
  // Watchdog counter and sticky flag
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      wcnt_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wcnt_q    <= wcnt_d;
      timeout_q <= timeout_d;
    end
  end
  assign o_timeout = timeout_q;
`else
  assign o_timeout = 1'b0;
`endif

  assign o_start        = start_q;
  assign o_busy         = busy_q;
  assign o_count        = count_q;
  assign o_multiplier   = opa_q;
  assign o_multiplicand = opb_q;

endmodule
